// File: rtl/cpu_instruction_prefetch_ctrl_if.sv
// Fetch/return/FIFO-write bundle between the prefetch sequencer, instruction memory and instruction FIFO.
// The master side is the sequencer; the slave side is the memory/FIFO/pipeline environment.
interface cpu_instruction_prefetch_ctrl_if #(
    parameter int ADDRESS_BITS = 16,
    parameter int INSTR_BITS   = 16
);
    logic                             mem_rd_req;
    logic [ADDRESS_BITS-1:0]          mem_addr;
    logic                             mem_ready;
    logic                             mem_valid;
    logic [INSTR_BITS-1:0]            mem_data;
    logic                             branch;
    logic [ADDRESS_BITS-1:0]          branch_target;
    logic                             halt;
    logic                             fifo_rd;
    logic                             fifo_wr;
    logic [ADDRESS_BITS+INSTR_BITS-1:0] fifo_data;
    logic                             fifo_flush;

    modport master (
        output mem_rd_req, mem_addr, fifo_wr, fifo_data, fifo_flush,
        input  mem_ready, mem_valid, mem_data, branch, branch_target, halt, fifo_rd
    );

    modport slave (
        input  mem_rd_req, mem_addr, fifo_wr, fifo_data, fifo_flush,
        output mem_ready, mem_valid, mem_data, branch, branch_target, halt, fifo_rd
    );
endinterface

// File: rtl/cpu_instruction_prefetch_ctrl.sv
// In-order instruction prefetch sequencer: credit-limited fetches, PC-tagged FIFO writes, branch flush.
// Latency: request the cycle after reset/flush; return written to the FIFO in the mem_valid cycle.
// Backpressure: mem_addr holds while mem_ready=0; requests stop when occ+outstanding reaches FIFO capacity.
module cpu_instruction_prefetch_ctrl #(
    parameter int ADDRESS_BITS    = 16,
    parameter int INSTR_BITS      = 16,
    parameter int FIFO_DEPTH_BITS = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RESET_PC        = 0
) (
    input logic CLK,
    input logic RSTb,
    cpu_instruction_prefetch_ctrl_if.master bus
);
    localparam int CAP = (1 << FIFO_DEPTH_BITS) - 1;
    localparam logic [FIFO_DEPTH_BITS:0] LP_CAP  = (FIFO_DEPTH_BITS+1)'(CAP);
    localparam logic [1:0]               LP_MAXO = 2'(MAX_OUTSTANDING);
    localparam logic [ADDRESS_BITS-1:0]  LP_RPC  = ADDRESS_BITS'(RESET_PC);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [ADDRESS_BITS-1:0]      r_fetch_pc;
    logic [ADDRESS_BITS-1:0]      r_ret_pc;
    logic [FIFO_DEPTH_BITS-1:0]   r_occ;
    logic [1:0]                   r_outst;
    logic [1:0]                   r_discard;

    logic [FIFO_DEPTH_BITS:0]     w_credit_sum;
    logic                         w_credit_ok;
    logic                         w_mem_rd_req;
    logic                         w_fifo_wr;
    logic                         w_fifo_flush;
    logic                         w_accept;
    logic                         w_rd_eff;

    // Credit counts both stored words and words still in flight, so a FIFO slot is reserved per request.
    assign w_credit_sum = {1'b0, r_occ} + (FIFO_DEPTH_BITS+1)'(r_outst);
    assign w_credit_ok  = (r_outst < LP_MAXO) && (w_credit_sum < LP_CAP);
    assign w_accept     = w_mem_rd_req & bus.mem_ready;
    assign w_rd_eff     = bus.fifo_rd && (r_occ != '0);

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_FETCH;
        case (r_state)
            ST_FETCH: w_state_nxt = bus.branch ? ST_FLUSH : ST_FETCH;
            ST_FLUSH: w_state_nxt = bus.branch ? ST_FLUSH : ST_FETCH;
            default:  w_state_nxt = ST_FETCH;
        endcase
    end

    // Outputs are gated by RSTb so nothing leaks out during the reset cycles themselves.
    always_comb begin
        w_mem_rd_req = 1'b0;
        w_fifo_flush = 1'b0;
        w_fifo_wr    = 1'b0;
        if (RSTb) begin
            w_fifo_wr = bus.mem_valid && (r_discard == '0) && !bus.branch;
            case (r_state)
                ST_FETCH: w_mem_rd_req = !bus.halt && !bus.branch && w_credit_ok;
                ST_FLUSH: w_fifo_flush = 1'b1;
                default:  w_mem_rd_req = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_fetch_pc <= LP_RPC;
            r_ret_pc   <= LP_RPC;
            r_occ      <= '0;
            r_outst    <= '0;
            r_discard  <= '0;
        end else begin
            r_outst <= r_outst + 2'(w_accept) - 2'(bus.mem_valid);
            if (bus.branch) begin
                // Everything still in flight after this cycle's return belongs to the old path.
                r_fetch_pc <= bus.branch_target;
                r_ret_pc   <= bus.branch_target;
                r_occ      <= '0;
                r_discard  <= r_outst - 2'(bus.mem_valid);
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 1'b1;
                end
                if (w_fifo_wr) begin
                    r_ret_pc <= r_ret_pc + 1'b1;
                end
                if (r_state == ST_FLUSH) begin
                    r_occ <= '0;
                end else begin
                    r_occ <= r_occ + FIFO_DEPTH_BITS'(w_fifo_wr) - FIFO_DEPTH_BITS'(w_rd_eff);
                end
                if (bus.mem_valid && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
            end
        end
    end

    assign bus.mem_rd_req = w_mem_rd_req;
    assign bus.mem_addr   = r_fetch_pc;
    assign bus.fifo_wr    = w_fifo_wr;
    assign bus.fifo_data  = {r_ret_pc, bus.mem_data};
    assign bus.fifo_flush = w_fifo_flush;

endmodule

// File: tb/tb_cpu_instruction_prefetch_ctrl.sv
// Bench for the prefetch sequencer: directed scenarios plus randomized traffic against a queue-based model.
// The model tracks in-flight fetches as a list of tagged PCs and the FIFO as a word count.
module tb_cpu_instruction_prefetch_ctrl;
    localparam int AB   = 16;
    localparam int IB   = 16;
    localparam int FDB  = 4;
    localparam int MAXO = 2;
    localparam int RPC  = 0;
    localparam int CAP  = (1 << FDB) - 1;

    logic CLK = 1'b0;
    logic RSTb = 1'b0;
    always #5 CLK = ~CLK;

    cpu_instruction_prefetch_ctrl_if #(.ADDRESS_BITS(AB), .INSTR_BITS(IB)) bus ();

    cpu_instruction_prefetch_ctrl #(
        .ADDRESS_BITS(AB), .INSTR_BITS(IB), .FIFO_DEPTH_BITS(FDB),
        .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
    ) u_dut (
        .CLK(CLK),
        .RSTb(RSTb),
        .bus(bus)
    );

    typedef struct {
        logic [AB-1:0] pc;
        int            due;
        bit            dead;
    } fl_t;

    fl_t           q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            fq_cnt = 0;
    logic [AB-1:0] m_pc = AB'(RPC);
    bit            m_flush = 0;
    bit            rst_low_prev = 0;
    int            acc_cnt = 0;
    int            wr_cnt = 0;
    logic [AB-1:0] last_wr_pc = '0;
    logic [AB-1:0] first_wr_pc = '0;
    logic [IB-1:0] first_wr_dat = '0;
    logic [AB-1:0] last_acc_addr = '0;
    int            lat_min = 1;
    int            lat_max = 1;

    function automatic logic [IB-1:0] hashf(input logic [AB-1:0] a);
        logic [31:0] t;
        t = a * 32'd40503 + 32'h1234;
        return t[IB-1:0] ^ t[31:16];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare process: checks outputs against the model, then advances the model by one cycle.
    always @(negedge CLK) begin
        bit                 e_req, e_wr, acc, rd;
        logic [AB+IB-1:0]   e_dat;
        fl_t                f, nf;
        if (!RSTb) begin
            chk("rst_mem_rd_req", bus.mem_rd_req, 0);
            chk("rst_fifo_wr", bus.fifo_wr, 0);
            chk("rst_fifo_flush", bus.fifo_flush, 0);
            if (rst_low_prev) chk("rst_mem_addr", bus.mem_addr, RPC);
            q.delete();
            fq_cnt = 0;
            m_pc = AB'(RPC);
            m_flush = 0;
            acc_cnt = 0;
            wr_cnt = 0;
            rst_low_prev = 1;
        end else begin
            rst_low_prev = 0;
            e_req = !m_flush && !bus.halt && !bus.branch && (q.size() < MAXO) &&
                    (fq_cnt + q.size() < CAP);
            e_wr = 0;
            e_dat = '0;
            if (bus.mem_valid && q.size() > 0) begin
                f = q[0];
                e_wr = !f.dead && !bus.branch;
                e_dat = {f.pc, hashf(f.pc)};
            end
            chk("mem_rd_req", bus.mem_rd_req, e_req);
            chk("mem_addr", bus.mem_addr, m_pc);
            chk("fifo_flush", bus.fifo_flush, m_flush);
            chk("fifo_wr", bus.fifo_wr, e_wr);
            if (e_wr) chk("fifo_data", bus.fifo_data, e_dat);
            if (bus.fifo_wr) begin
                if (wr_cnt == 0) begin
                    first_wr_pc = bus.fifo_data[AB+IB-1:IB];
                    first_wr_dat = bus.fifo_data[IB-1:0];
                end
                wr_cnt++;
                last_wr_pc = bus.fifo_data[AB+IB-1:IB];
            end
            if (bus.mem_rd_req && bus.mem_ready) begin
                acc_cnt++;
                last_acc_addr = bus.mem_addr;
            end
            acc = e_req && bus.mem_ready;
            rd = bus.fifo_rd && !m_flush && (fq_cnt > 0);
            if (bus.mem_valid && q.size() > 0) void'(q.pop_front());
            fq_cnt = fq_cnt + int'(e_wr) - int'(rd);
            if (bus.branch) begin
                foreach (q[i]) q[i].dead = 1;
                fq_cnt = 0;
                m_pc = bus.branch_target;
                m_flush = 1;
            end else begin
                m_flush = 0;
                if (acc) begin
                    nf.pc = m_pc;
                    nf.due = cyc + int'($urandom_range(lat_min, lat_max));
                    nf.dead = 0;
                    q.push_back(nf);
                    m_pc = m_pc + 1'b1;
                end
            end
        end
        cyc++;
    end

    task automatic drive_mem();
        if (RSTb && q.size() > 0 && q[0].due <= cyc) begin
            bus.mem_valid = 1'b1;
            bus.mem_data  = hashf(q[0].pc);
        end else begin
            bus.mem_valid = 1'b0;
            bus.mem_data  = IB'($urandom);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        bus.branch = 1'b0;
        drive_mem();
    endtask

    task automatic do_reset();
        step();
        RSTb = 1'b0;
        bus.halt = 1'b0;
        bus.fifo_rd = 1'b0;
        bus.mem_ready = 1'b0;
        drive_mem();
        repeat (3) step();
        RSTb = 1'b1;
    endtask

    task automatic wait_wr_after(input int mark, input int budget, input string nm);
        int n;
        n = 0;
        while (wr_cnt <= mark && n < budget) begin
            step();
            n++;
        end
        if (wr_cnt <= mark) chk(nm, 0, 1);
    endtask

    initial begin
        int n;
        int mark;
        bit found;
        bus.mem_ready = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_data = '0;
        bus.branch = 1'b0;
        bus.branch_target = '0;
        bus.halt = 1'b0;
        bus.fifo_rd = 1'b0;

        // Fill: no reads, memory always ready, one-cycle return.
        lat_min = 1; lat_max = 1;
        do_reset();
        bus.mem_ready = 1'b1;
        @(negedge CLK);
        chk("first_req", bus.mem_rd_req, 1);
        chk("first_addr", bus.mem_addr, 16'h0000);
        repeat (40) step();
        chk("fill_writes", wr_cnt, 15);
        chk("fill_accepts", acc_cnt, 15);
        chk("fill_first_pc", first_wr_pc, 16'h0000);
        chk("fill_first_dat", first_wr_dat, hashf(16'h0000));
        chk("fill_last_pc", last_wr_pc, 16'h000E);
        @(negedge CLK);
        chk("fill_req_low", bus.mem_rd_req, 0);
        step();
        bus.fifo_rd = 1'b1;
        step();
        bus.fifo_rd = 1'b0;
        repeat (10) step();
        chk("credit_one_more_acc", acc_cnt, 16);
        chk("credit_one_more_wr", wr_cnt, 16);
        chk("credit_addr", last_acc_addr, 16'h000F);

        // Memory stall: the request must hold its address.
        do_reset();
        repeat (5) step();
        @(negedge CLK);
        chk("stall_addr", bus.mem_addr, 16'h0000);
        chk("stall_req", bus.mem_rd_req, 1);
        chk("stall_acc", acc_cnt, 0);

        // Branch with two fetches in flight (0x10, 0x11).
        lat_min = 4; lat_max = 4;
        do_reset();
        bus.mem_ready = 1'b1;
        bus.fifo_rd = 1'b1;
        step();
        bus.branch = 1'b1;
        bus.branch_target = 16'h0010;
        found = 0;
        for (n = 0; n < 50 && !found; n++) begin
            step();
            if (q.size() == 2 && q[0].pc == 16'h0010 && q[1].pc == 16'h0011 && !bus.mem_valid)
                found = 1;
        end
        chk("br2_setup", found, 1);
        bus.branch = 1'b1;
        bus.branch_target = 16'h0080;
        mark = wr_cnt;
        step();
        @(negedge CLK);
        chk("br2_flush", bus.fifo_flush, 1);
        wait_wr_after(mark, 40, "br2_timeout");
        chk("br2_first_pc", last_wr_pc, 16'h0080);

        // Branch coincident with a return while another fetch is in flight.
        lat_min = 2; lat_max = 2;
        found = 0;
        for (n = 0; n < 60 && !found; n++) begin
            step();
            if (q.size() == 2 && bus.mem_valid && !q[0].dead && !q[1].dead) found = 1;
        end
        chk("brv_setup", found, 1);
        bus.branch = 1'b1;
        bus.branch_target = 16'h0200;
        mark = wr_cnt;
        @(negedge CLK);
        chk("brv_no_wr", bus.fifo_wr, 0);
        wait_wr_after(mark, 40, "brv_timeout");
        chk("brv_first_pc", last_wr_pc, 16'h0200);

        // Halt with one fetch outstanding.
        lat_min = 3; lat_max = 3;
        do_reset();
        bus.mem_ready = 1'b1;
        found = 0;
        for (n = 0; n < 10 && !found; n++) begin
            step();
            if (q.size() == 1) begin
                bus.halt = 1'b1;
                found = 1;
            end
        end
        chk("halt_setup", found, 1);
        repeat (6) step();
        chk("halt_wr", wr_cnt, 1);
        chk("halt_acc", acc_cnt, 1);
        bus.halt = 1'b0;
        step();
        chk("resume_acc", acc_cnt, 2);
        chk("resume_addr", last_acc_addr, 16'h0001);

        // Randomized traffic.
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step();
            bus.mem_ready = ($urandom % 4) != 0;
            bus.fifo_rd = ($urandom % 3) == 0;
            bus.halt = ($urandom % 10) == 0;
            if ($urandom % 30 == 0) begin
                bus.branch = 1'b1;
                bus.branch_target = ($urandom % 4 == 0) ? 16'hFFFE : AB'($urandom);
            end
            if ($urandom % 1500 == 0) do_reset();
        end
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_instruction_prefetch_ctrl.md
# cpu_instruction_prefetch_ctrl

Prefetch sequencer for the CPU instruction FIFO. It issues in-order instruction fetch requests to the memory interface. Each returned word is tagged with its PC and written into the instruction FIFO. The block keeps a credit count so the FIFO can never overflow, and flushes the FIFO and all in-flight fetches when the pipeline redirects on a branch.

## Interface
Parameters:
- ADDRESS_BITS, 16, PC / word-address width
- INSTR_BITS, 16, instruction word width
- FIFO_DEPTH_BITS, 4, depth bits of the attached FIFO; usable capacity CAP = 2^FIFO_DEPTH_BITS - 1
- MAX_OUTSTANDING, 2, maximum accepted-but-not-returned fetches (1..3)
- RESET_PC, 0, first fetch address after reset

Ports:
- CLK  in  1  clock; one clock for the whole block
- RSTb  in  1  synchronous, active-low reset
- mem_rd_req  out  1  fetch request (valid)
- mem_addr  out  ADDRESS_BITS  fetch word address; stable while mem_rd_req=1 and mem_ready=0
- mem_ready  in  1  request accepted when mem_rd_req & mem_ready
- mem_valid  in  1  one returned word, in request order; never in the same cycle the request is accepted
- mem_data  in  INSTR_BITS  returned word
- branch  in  1  one-cycle pipeline redirect
- branch_target  in  ADDRESS_BITS  new PC, sampled when branch=1
- halt  in  1  1 => issue no new requests; returns are still written
- fifo_rd  in  1  mirror of the CPU's FIFO read strobe
- fifo_wr  out  1  FIFO write strobe
- fifo_data  out  ADDRESS_BITS+INSTR_BITS  {pc, instruction}
- fifo_flush  out  1  one-cycle pulse; FIFO reset is driven as RSTb & ~fifo_flush

## Operation
- State machine has two states, FETCH and FLUSH. Reset enters FETCH.
- Registers:
  - fetch_pc: next address to request.
  - ret_pc: PC of the next non-discarded return.
  - occ: FIFO occupancy, 0..CAP.
  - outst: all in-flight fetches, 0..MAX_OUTSTANDING.
  - discard: in-flight fetches to drop, discard ≤ outst.
- mem_rd_req = FETCH & ~halt & ~branch & (outst < MAX_OUTSTANDING) & (occ + outst < CAP). Width rule: compute occ + outst at FIFO_DEPTH_BITS+1 bits.
- mem_addr = fetch_pc.
- Request accept: fetch_pc += 1 (wraps modulo 2^ADDRESS_BITS) and outst += 1.
- Every mem_valid decrements outst.
  - If discard > 0, the word is dropped and discard decrements.
  - Otherwise, if branch=0, fifo_wr=1 combinationally, fifo_data={ret_pc, mem_data}, and ret_pc += 1.
- occ_next = occ + fifo_wr - (fifo_rd & occ≠0). A simultaneous write and read leaves occ unchanged.
- Branch (any state):
  - Next state FLUSH.
  - fetch_pc and ret_pc ← branch_target; occ ← 0.
  - discard ← outst - mem_valid.
  - A return arriving in the branch cycle is dropped.
- FLUSH lasts one cycle: fifo_flush=1, no request, fifo_rd ignored, occ held at 0. Next state FETCH.
  - A return arriving during FLUSH is always dropped, since discard counts it.
- Branch during FLUSH: branch_target is re-sampled and the block stays in FLUSH one more cycle.
- halt does not affect flush, return, or discard handling.
- Reset mid-operation clears all state. The memory side must also be reset, so no stale return arrives after reset.

## Timing
- Reset values:
  - mem_rd_req=0 while RSTb=0.
  - mem_addr=RESET_PC.
  - fifo_wr=0, fifo_flush=0.
  - occ=outst=discard=0; state FETCH.
- First request is issued the cycle after RSTb rises, at address RESET_PC.
- Return to FIFO has zero added latency: fifo_wr is asserted in the same cycle as mem_valid.
  - The FIFO output is valid one cycle after the write.
- Branch at cycle t: fifo_flush=1 at t+1; first request to branch_target at t+2, at the earliest.
- Credit is conservative: a read in cycle t frees credit for a request at t+1.

## Test plan
- Reset → mem_rd_req=1, mem_addr=0x0000 the cycle after reset release. With mem_ready=1 and 1-cycle return, fifo_data = {0x0000,d0}, {0x0001,d1}, … in order.
- No fifo_rd, memory always ready → exactly 15 FIFO writes (FIFO_DEPTH_BITS=4). mem_rd_req stays 0 after occ+outst=15. One fifo_rd → exactly one more request.
- mem_ready=0 for 5 cycles with a request pending → mem_addr held constant, no fetch_pc advance, outst unchanged.
- Two fetches outstanding (0x10, 0x11), branch to 0x80 → fifo_flush one cycle later. Both returns are dropped. The next write is {0x0080, data}.
- Branch coincident with mem_valid, one other fetch in flight → that return is dropped, and the later return is dropped too (discard=1). The first write after the flush carries pc=branch_target.
- halt=1 with one fetch outstanding → its return is still written and no new request is issued. Deasserting halt resumes fetch at the next sequential address.
